// File: rtl/serial_frame_pkg.sv
// ---------------------------------------------------------------------------
// serial_frame_pkg
//   Shared definitions for the serial frame receiver:
//     - rx_state_e   : receiver FSM state encoding
//     - START_BIT / STOP_BIT line levels
//     - DATA_W_DEF   : default data bits per frame
//     - parity_bad() : 1 when data+parity bit do not satisfy the parity mode
// ---------------------------------------------------------------------------
package serial_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam int   DATA_W_DEF = 8;
   localparam int   PAR_MAX_W  = 64;

   // Caller zero-extends its data word; extra zeros do not change the XOR.
   function automatic logic parity_bad(input logic [PAR_MAX_W-1:0] data,
                                       input logic                 pbit,
                                       input logic                 odd);
      return (^data) ^ pbit ^ odd;
   endfunction

endpackage

// File: rtl/frame_obuf.sv
// ---------------------------------------------------------------------------
// frame_obuf
//   2-entry synchronous FIFO holding received bytes.
//   Ports:
//     clk, rst_n    clock / async active-low reset
//     push_i        write data_i this cycle
//     data_i        byte to write
//     pop_i         consumer accepts head (ignored while empty)
//     dout_o        head entry, 0 when empty
//     valid_o       FIFO not empty
//     full_o        FIFO holds 2 entries
//     overflow_o    one-cycle pulse: push while full without a pop, dropped
// ---------------------------------------------------------------------------
module frame_obuf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         valid_o,
   output logic         full_o,
   output logic         overflow_o
);

   logic [W-1:0] mem_q [2];
   logic         rd_q, wr_q;
   logic [1:0]   cnt_q;
   logic         overflow_q;
   logic         pop_w, wr_en_w;

   assign valid_o    = (cnt_q != 2'd0);
   assign full_o     = (cnt_q == 2'd2);
   assign pop_w      = pop_i && valid_o;
   // A pop in the same cycle frees the slot the push needs.
   assign wr_en_w    = push_i && (!full_o || pop_w);
   assign dout_o     = valid_o ? mem_q[rd_q] : '0;
   assign overflow_o = overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         cnt_q      <= 2'd0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= push_i && !wr_en_w;
         if (wr_en_w) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ~wr_q;
         end
         if (pop_w) rd_q <= ~rd_q;
         case ({wr_en_w, pop_w})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//   Receives framed characters (start 0, DATA_W data bits LSB first, parity,
//   stop 1) from a qualified serial bit stream and buffers good bytes in a
//   2-entry FIFO drained by valid/ready.
//   Ports:
//     clk, rst_n     clock / async active-low reset
//     sin, sin_en    serial bit and its qualifier (state moves only on sin_en)
//     dout           head byte of output buffer (0 when empty)
//     dout_valid     buffer not empty
//     dout_ready     consumer accepts dout
//     busy           FSM not idle
//     parity_err     pulse: parity mismatch, byte dropped
//     frame_err      pulse: stop bit 0 (or mid-frame timeout), byte dropped
//     overflow       pulse: good byte arrived while buffer full, dropped
//   Optional: define RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYC
//   consecutive unqualified cycles while busy.
// ---------------------------------------------------------------------------
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter bit PARITY_ODD  = 1'b0,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin,
   input  logic              sin_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overflow
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   rx_state_e         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] data_q;
   logic              par_ok_q;
   logic              parity_err_q, frame_err_q;
   logic              push_w;
   logic              tmo_hit;
   logic              full_unused;

`ifdef RX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q;

   assign tmo_hit = busy && !sin_en && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     tmo_q <= '0;
      else if (sin_en || !busy || tmo_hit) tmo_q <= '0;
      else                            tmo_q <= tmo_q + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign busy       = (state_q != ST_IDLE);
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

   // Push at the stop-bit edge so the byte is visible the following cycle.
   assign push_w = sin_en && (state_q == ST_STOP) && (sin == STOP_BIT) && par_ok_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         data_q       <= '0;
         par_ok_q     <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (tmo_hit) begin
            state_q     <= ST_IDLE;
            frame_err_q <= 1'b1;
         end else if (sin_en) begin
            case (state_q)
               ST_IDLE: begin
                  if (sin == START_BIT) begin
                     state_q <= ST_DATA;
                     cnt_q   <= '0;
                  end
               end
               ST_DATA: begin
                  data_q[cnt_q] <= sin;
                  cnt_q         <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_ok_q <= !parity_bad(PAR_MAX_W'(data_q), sin, PARITY_ODD);
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  // Bad stop bit outranks a parity mismatch.
                  if (sin != STOP_BIT)  frame_err_q  <= 1'b1;
                  else if (!par_ok_q)   parity_err_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   frame_obuf #(.W(DATA_W)) u_obuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push_w),
      .data_i     (data_q),
      .pop_i      (dout_ready),
      .dout_o     (dout),
      .valid_o    (dout_valid),
      .full_o     (full_unused),
      .overflow_o (overflow)
   );

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sin, sin_en, dout_ready;
   logic [7:0] dout;
   logic       dout_valid, busy, parity_err, frame_err, overflow;

   int n_chk  = 0;
   int n_fail = 0;

   serial_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0), .TIMEOUT_CYC(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin        (sin),
      .sin_en     (sin_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin    = b;
      sin_en = 1'b1;
      tick();
   endtask

   task automatic idle();
      sin    = 1'b1;
      sin_en = 1'b1;
      tick();
   endtask

   // Unqualified cycles between bits; the line carries junk and busy must hold.
   task automatic gaps(input int n);
      for (int g = 0; g < n; g++) begin
         sin_en = 1'b0;
         sin    = 1'($urandom);
         tick();
         check("busy_gap", busy, 1);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pb, input logic stp, input int gap);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         gaps(gap);
         send_bit(d[i]);
      end
      gaps(gap);
      send_bit(pb);
      gaps(gap);
      send_bit(stp);
   endtask

   initial begin
      rst_n = 1'b0; sin = 1'b1; sin_en = 1'b0; dout_ready = 1'b0;
      #23;
      check("rst_dout", dout, 8'h00);
      check("rst_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_errs", {parity_err, frame_err, overflow}, 3'b000);
      rst_n = 1'b1;
      tick();
      idle();

      // Good frame 0xA5: check just before and just after the stop bit
      send_bit(1'b0);
      check("a5_busy", busy, 1);
      for (int i = 0; i < 8; i++) send_bit(1'(8'hA5 >> i));
      send_bit(^8'hA5);
      check("a5_pre_valid", dout_valid, 0);
      send_bit(1'b1);
      check("a5_valid", dout_valid, 1);
      check("a5_dout", dout, 8'hA5);
      check("a5_errs", {parity_err, frame_err, overflow}, 3'b000);
      check("a5_idle", busy, 0);
      idle();
      check("a5_hold", dout, 8'hA5);
      dout_ready = 1'b1;
      idle();
      check("a5_pop_valid", dout_valid, 0);
      check("a5_pop_dout", dout, 8'h00);
      dout_ready = 1'b0;

      // Parity error: 0x3C with wrong parity bit
      send_frame(8'h3C, ~^8'h3C, 1'b1, 0);
      check("par_err", parity_err, 1);
      check("par_ferr", frame_err, 0);
      check("par_valid", dout_valid, 0);
      idle();
      check("par_pulse", parity_err, 0);

      // Frame error: 0x55 with stop 0, then 0x81 back to back
      send_frame(8'h55, ^8'h55, 1'b0, 0);
      check("frm_err", frame_err, 1);
      check("frm_perr", parity_err, 0);
      check("frm_valid", dout_valid, 0);
      send_frame(8'h81, ^8'h81, 1'b1, 0);
      check("frm_pulse", frame_err, 0);
      check("81_valid", dout_valid, 1);
      check("81_dout", dout, 8'h81);
      dout_ready = 1'b1;
      idle();
      check("81_pop", dout_valid, 0);
      dout_ready = 1'b0;

      // Overflow: three frames back to back with no consumer
      send_frame(8'h01, ^8'h01, 1'b1, 0);
      send_frame(8'h02, ^8'h02, 1'b1, 0);
      check("ovf_none", overflow, 0);
      send_frame(8'h03, ^8'h03, 1'b1, 0);
      check("ovf_pulse", overflow, 1);
      check("ovf_head", dout, 8'h01);
      dout_ready = 1'b1;
      idle();
      check("ovf_clear", overflow, 0);
      check("ovf_pop1", dout, 8'h02);
      check("ovf_pop1_v", dout_valid, 1);
      idle();
      check("ovf_pop2_v", dout_valid, 0);
      dout_ready = 1'b0;

      // Gapped bits: 0xC3 with 3 idle qualifier cycles between every bit
      send_frame(8'hC3, ^8'hC3, 1'b1, 3);
      check("c3_valid", dout_valid, 1);
      check("c3_dout", dout, 8'hC3);
      check("c3_errs", {parity_err, frame_err, overflow}, 3'b000);

      // Reset mid-frame with 0xC3 still buffered
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      check("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", dout_valid, 0);
      check("mid_rst_dout", dout, 8'h00);
      tick();
      rst_n = 1'b1;
      idle();
      send_frame(8'h7E, ^8'h7E, 1'b1, 0);
      check("7e_valid", dout_valid, 1);
      check("7e_dout", dout, 8'h7E);
      check("7e_errs", {parity_err, frame_err, overflow}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
